dmem_port_arbiter: RTL and testbench
====================================

# dmem_port_arbiter

Sequences and shares the single data-memory port between the pipeline's MEM stage (core) and a secondary DMA/loader master. Sits directly in front of DataMem: the core keeps zero-latency priority, the DMA gets bounded-latency bursts. The core is stalled only while the DMA owns the port. DMA read data is returned registered, with a valid strobe.

## Interface
- DATA_WIDTH, 32, data and address width
- MAX_WAIT, 8, max consecutive cycles a pending DMA request is denied while the core is busy (≥1)
- BURST_MAX, 4, max consecutive DMA beats granted while the core is waiting (≥1)

Ports:
- clk  in  1  clock; all state updates on rising edge
- n_rst  in  1  reset; synchronous, active-low
- i_core_MemRead  in  1  core load request
- i_core_MemWrite  in  1  core store request
- i_core_Mode  in  3  funct3 size/sign mode (00 byte, 01 half, 10 word; bit2 unsigned)
- i_core_Addr  in  DATA_WIDTH  core byte address
- i_core_WriteData  in  DATA_WIDTH  core store data
- o_core_MemOut  out  DATA_WIDTH  core load data (combinational from memory)
- o_core_stall  out  1  core access not served this cycle; hold pipeline
- i_dma_req  in  1  DMA beat request
- i_dma_we  in  1  DMA beat is write (1) or read (0)
- i_dma_Mode  in  3  DMA size/sign mode, same encoding
- i_dma_Addr  in  DATA_WIDTH  DMA byte address
- i_dma_WriteData  in  DATA_WIDTH  DMA store data
- o_dma_gnt  out  1  DMA beat accepted at this edge
- o_dma_rdata  out  DATA_WIDTH  registered DMA read data
- o_dma_rvalid  out  1  o_dma_rdata valid (1-cycle pulse)
- o_mem_MemRead, o_mem_MemWrite  out  1 each  to DataMem
- o_mem_Mode  out  3  to DataMem
- o_mem_Addr, o_mem_WriteData  out  DATA_WIDTH each  to DataMem
- i_mem_MemOut  in  DATA_WIDTH  from DataMem (combinational read)
- o_owner  out  1  0 = core owns port, 1 = DMA owns port

## Operation
- core_req = i_core_MemRead | i_core_MemWrite.
- Registered state: S_CORE (owner 0) or S_DMA (owner 1), wait_cnt, beat_cnt.
- The memory-side mux selects on state only; no combinational grant from requests.
- S_CORE: memory ports mirror core inputs. o_core_stall=0, o_dma_gnt=0.
- S_DMA: memory ports carry the DMA beat with MemRead=i_dma_req&!i_dma_we and MemWrite=i_dma_req&i_dma_we. o_dma_gnt=i_dma_req; o_core_stall=core_req.
- S_CORE→S_DMA when i_dma_req & (!core_req | wait_cnt==MAX_WAIT-1).
- S_DMA→S_CORE when !i_dma_req, or when core_req & beat_cnt==BURST_MAX-1.
- wait_cnt:
  - increments while in S_CORE with i_dma_req & core_req; saturates at MAX_WAIT-1;
  - clears when i_dma_req=0 or on entering S_DMA.
- beat_cnt:
  - increments per accepted beat while core_req=1; saturates at BURST_MAX-1;
  - clears on entering S_CORE.
  - Without core demand, DMA bursts are unbounded.
- DMA handshake:
  - DMA holds req/we/Mode/Addr/WriteData stable until an edge with o_dma_gnt=1, then may present the next beat.
  - Dropping req is legal only after an accepted beat.
- DMA read: on an accepted read beat, i_mem_MemOut is captured into o_dma_rdata and o_dma_rvalid=1 for the following cycle.
- o_core_MemOut = i_mem_MemOut at all times. The core ignores it when stalled.

## Timing
- Reset (n_rst=0 at an edge): state=S_CORE, wait_cnt=0, beat_cnt=0, o_dma_rdata=0, o_dma_rvalid=0, o_owner=0.
- While n_rst=0: o_mem_MemRead and o_mem_MemWrite are forced 0, o_dma_gnt=0, o_core_stall=0.
- Reset mid-burst abandons the burst. A beat is not accepted in a reset cycle.
- Core latency: 0 cycles in S_CORE. A stalled core is served on the first cycle after the return to S_CORE.
- DMA latency:
  - first beat ≥1 cycle after req rises (state switch);
  - worst case MAX_WAIT cycles under continuous core traffic.
- Core worst-case stall: BURST_MAX cycles.
- Read data for a DMA beat accepted at edge N is valid in cycle N+1. Back-to-back reads give back-to-back rvalid.
- Simultaneous i_dma_req rise and core_req in S_CORE: core is served and wait_cnt starts.
- Core store and DMA never reach memory in the same cycle. The state register is the sole owner select.

## Test plan
- Reset: hold n_rst=0 for 2 cycles with both masters requesting → o_mem_MemWrite=0, o_owner=0, o_dma_rvalid=0. After release, the core store to 0x100 of 0xDEADBEEF reaches memory the same cycle.
- Idle core, DMA reads of 0x200 and 0x204 (memory holds 0x11, 0x22):
  - o_owner=1 after 1 cycle;
  - gnt on 2 consecutive edges;
  - o_dma_rvalid pulses with 0x11 then 0x22;
  - return to S_CORE the cycle after req drops.
- Core starvation bound, MAX_WAIT=8, core_req held continuously, DMA req raised → DMA owns the port exactly 8 cycles later. o_core_stall=1 for BURST_MAX=4 cycles, then the core resumes.
- DMA burst preemption: DMA issues a 10-beat write burst with the core idle; core raises MemRead at beat 2 → core stalled while 4 beats complete (beats 2–5), port returns to the core, and the remaining DMA beats resume after wait_cnt/idle rules apply.
- Mid-burst reset: n_rst=0 during beat 3 of a DMA write burst → beat 3 is not written (memory at that address unchanged), state=S_CORE, counters 0.
- Mode passthrough: DMA byte write (Mode=000) of 0xAB to 0x301, then core word read of 0x300 → core sees byte 1 = 0xAB and the other bytes unchanged.

Source files
------------

// File: rtl/dmem_port_arbiter.sv
// dmem_port_arbiter: shares the single DataMem port between the core MEM
// stage and a DMA/loader master. The core has zero-latency priority; the DMA
// gets bounded-latency bursts. Owner is chosen only by the registered state.
module dmem_port_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned MAX_WAIT   = 8,
    parameter int unsigned BURST_MAX  = 4
) (
    input  logic                  clk,
    input  logic                  n_rst,
    // core (MEM stage) side
    input  logic                  i_core_MemRead,
    input  logic                  i_core_MemWrite,
    input  logic [2:0]            i_core_Mode,
    input  logic [DATA_WIDTH-1:0] i_core_Addr,
    input  logic [DATA_WIDTH-1:0] i_core_WriteData,
    output logic [DATA_WIDTH-1:0] o_core_MemOut,
    output logic                  o_core_stall,
    // DMA side
    input  logic                  i_dma_req,
    input  logic                  i_dma_we,
    input  logic [2:0]            i_dma_Mode,
    input  logic [DATA_WIDTH-1:0] i_dma_Addr,
    input  logic [DATA_WIDTH-1:0] i_dma_WriteData,
    output logic                  o_dma_gnt,
    output logic [DATA_WIDTH-1:0] o_dma_rdata,
    output logic                  o_dma_rvalid,
    // DataMem side
    output logic                  o_mem_MemRead,
    output logic                  o_mem_MemWrite,
    output logic [2:0]            o_mem_Mode,
    output logic [DATA_WIDTH-1:0] o_mem_Addr,
    output logic [DATA_WIDTH-1:0] o_mem_WriteData,
    input  logic [DATA_WIDTH-1:0] i_mem_MemOut,
    output logic                  o_owner
);

    localparam int unsigned WAIT_W = (MAX_WAIT  > 1) ? $clog2(MAX_WAIT)  : 1;
    localparam int unsigned BEAT_W = (BURST_MAX > 1) ? $clog2(BURST_MAX) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);
    localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(BURST_MAX - 1);

    typedef enum logic {
        S_CORE = 1'b0,
        S_DMA  = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [WAIT_W-1:0]     wait_q,  wait_d;
    logic [BEAT_W-1:0]     beat_q,  beat_d;
    logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
    logic                  rvalid_q, rvalid_d;

    logic core_req;
    logic dma_accept;

    assign core_req   = i_core_MemRead | i_core_MemWrite;
    // A beat is accepted only while the DMA owns the port and never in a reset cycle.
    assign dma_accept = (state_q == S_DMA) & i_dma_req & n_rst;

    assign o_owner       = (state_q == S_DMA);
    assign o_core_MemOut = i_mem_MemOut;
    assign o_dma_rdata   = rdata_q;
    assign o_dma_rvalid  = rvalid_q;

    // Memory-side mux and handshakes, selected by registered owner only.
    always_comb begin
        o_mem_MemRead   = i_core_MemRead;
        o_mem_MemWrite  = i_core_MemWrite;
        o_mem_Mode      = i_core_Mode;
        o_mem_Addr      = i_core_Addr;
        o_mem_WriteData = i_core_WriteData;
        o_core_stall    = 1'b0;
        o_dma_gnt       = 1'b0;
        if (state_q == S_DMA) begin
            o_mem_MemRead   = i_dma_req & ~i_dma_we;
            o_mem_MemWrite  = i_dma_req &  i_dma_we;
            o_mem_Mode      = i_dma_Mode;
            o_mem_Addr      = i_dma_Addr;
            o_mem_WriteData = i_dma_WriteData;
            o_dma_gnt       = i_dma_req;
            o_core_stall    = core_req;
        end
        // Reset blocks every memory strobe and handshake regardless of state.
        if (!n_rst) begin
            o_mem_MemRead  = 1'b0;
            o_mem_MemWrite = 1'b0;
            o_dma_gnt      = 1'b0;
            o_core_stall   = 1'b0;
        end
    end

    // Next owner plus starvation (wait) and burst (beat) counters.
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        beat_d  = beat_q;
        if (state_q == S_CORE) begin
            beat_d = '0;
            if (!i_dma_req) begin
                wait_d = '0;
            end else if (!core_req || (wait_q == WAIT_LAST)) begin
                state_d = S_DMA;
                wait_d  = '0;
            end else begin
                // Core busy and DMA waiting below the bound: keep counting.
                wait_d = wait_q + 1'b1;
            end
        end else begin
            wait_d = '0;
            if (!i_dma_req) begin
                state_d = S_CORE;
                beat_d  = '0;
            end else if (core_req) begin
                if (beat_q == BEAT_LAST) begin
                    state_d = S_CORE;
                    beat_d  = '0;
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end
    end

    // DMA read return: capture memory data on an accepted read beat.
    always_comb begin
        rvalid_d = dma_accept & ~i_dma_we;
        rdata_d  = rvalid_d ? i_mem_MemOut : rdata_q;
    end

    // State, counters and read-return registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q  <= S_CORE;
            wait_q   <= '0;
            beat_q   <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            wait_q   <= wait_d;
            beat_q   <= beat_d;
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Testbench for dmem_port_arbiter: a byte-addressed DataMem model behind the
// arbiter, a per-cycle vector table, and directed multi-cycle sequences.
module tb_dmem_port_arbiter;

    localparam logic [2:0] MW = 3'b010;
    localparam logic [2:0] MB = 3'b000;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        core_rd, core_wr;
    logic [2:0]  core_mode;
    logic [31:0] core_addr, core_wd, core_out;
    logic        core_stall;
    logic        dma_req, dma_we, dma_gnt, dma_rvalid;
    logic [2:0]  dma_mode;
    logic [31:0] dma_addr, dma_wd, dma_rdata;
    logic        mem_rd, mem_wr;
    logic [2:0]  mem_mode;
    logic [31:0] mem_addr, mem_wd, mem_out;
    logic        owner;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    dmem_port_arbiter #(.DATA_WIDTH(32), .MAX_WAIT(8), .BURST_MAX(4)) dut (
        .clk(clk), .n_rst(n_rst),
        .i_core_MemRead(core_rd), .i_core_MemWrite(core_wr), .i_core_Mode(core_mode),
        .i_core_Addr(core_addr), .i_core_WriteData(core_wd), .o_core_MemOut(core_out),
        .o_core_stall(core_stall),
        .i_dma_req(dma_req), .i_dma_we(dma_we), .i_dma_Mode(dma_mode),
        .i_dma_Addr(dma_addr), .i_dma_WriteData(dma_wd), .o_dma_gnt(dma_gnt),
        .o_dma_rdata(dma_rdata), .o_dma_rvalid(dma_rvalid),
        .o_mem_MemRead(mem_rd), .o_mem_MemWrite(mem_wr), .o_mem_Mode(mem_mode),
        .o_mem_Addr(mem_addr), .o_mem_WriteData(mem_wd), .i_mem_MemOut(mem_out),
        .o_owner(owner)
    );

    // DataMem model: little-endian bytes, 1 KiB window.
    logic [7:0] mem [0:1023];
    logic [9:0] ma0, ma1, ma2, ma3;
    assign ma0 = 10'(mem_addr % 32'd1024);
    assign ma1 = ma0 + 10'd1;
    assign ma2 = ma0 + 10'd2;
    assign ma3 = ma0 + 10'd3;

    // Store bytes sized by mode.
    always @(posedge clk) begin
        if (mem_wr) begin
            mem[ma0] <= mem_wd[7:0];
            if (mem_mode[1:0] != 2'b00) mem[ma1] <= mem_wd[15:8];
            if (mem_mode[1:0] == 2'b10) begin
                mem[ma2] <= mem_wd[23:16];
                mem[ma3] <= mem_wd[31:24];
            end
        end
    end

    // Combinational load with size and sign handling.
    always_comb begin
        case (mem_mode[1:0])
            2'b00:   mem_out = {{24{~mem_mode[2] & mem[ma0][7]}}, mem[ma0]};
            2'b01:   mem_out = {{16{~mem_mode[2] & mem[ma1][7]}}, mem[ma1], mem[ma0]};
            default: mem_out = {mem[ma3], mem[ma2], mem[ma1], mem[ma0]};
        endcase
    end

    // Control bits in the order {owner, stall, gnt, mem_rd, mem_wr, rvalid}.
    function automatic logic [5:0] ctl();
        return {owner, core_stall, dma_gnt, mem_rd, mem_wr, dma_rvalid};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Waits for the falling edge, then applies one cycle of stimulus.
    task automatic drive(input logic r, crd, cwr, input logic [31:0] ca, cw,
                         input logic dq, dw, input logic [2:0] dm,
                         input logic [31:0] da, dd);
        @(negedge clk);
        n_rst = r; core_rd = crd; core_wr = cwr; core_mode = MW;
        core_addr = ca; core_wd = cw;
        dma_req = dq; dma_we = dw; dma_mode = dm; dma_addr = da; dma_wd = dd;
    endtask

    task automatic cyc(input string name, input logic [5:0] e);
        #1 chk(name, {26'd0, ctl()}, {26'd0, e});
    endtask

    task automatic core_write(input logic [31:0] a, d);
        drive(1, 0, 1, a, d, 0, 0, MW, 0, 0);
        cyc("core_write ctl", 6'b000010);
    endtask

    task automatic core_read_chk(input string name, input logic [31:0] a, exp);
        drive(1, 1, 0, a, 0, 0, 0, MW, 0, 0);
        cyc({name, " ctl"}, 6'b000100);
        chk(name, core_out, exp);
    endtask

    typedef struct {
        logic        rst_n, crd, cwr;
        logic [31:0] caddr, cwd;
        logic        dreq, dwe;
        logic [31:0] daddr, dwd;
        logic [5:0]  e_ctl;
        logic [31:0] e_maddr;
        int unsigned dchk;   // 0 none, 1 DMA rdata, 2 core load data
        logic [31:0] e_data;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic r, crd, cwr, input logic [31:0] ca, cw,
                                input logic dq, dw, input logic [31:0] da, dd,
                                input logic [5:0] ec, input logic [31:0] em,
                                input int unsigned dc, input logic [31:0] ed);
        vec_t v;
        v.rst_n = r; v.crd = crd; v.cwr = cwr; v.caddr = ca; v.cwd = cw;
        v.dreq = dq; v.dwe = dw; v.daddr = da; v.dwd = dd;
        v.e_ctl = ec; v.e_maddr = em; v.dchk = dc; v.e_data = ed;
        return v;
    endfunction

    initial begin
        // Reset held for two cycles with both masters requesting.
        vecs.push_back(mk(0, 0, 1, 32'h100, 32'hDEADBEEF, 1, 0, 32'h200, 0, 6'b000000, 32'h100, 0, 0));
        // Core store reaches memory in the first cycle after release; preload read data.
        vecs.push_back(mk(1, 0, 1, 32'h100, 32'hDEADBEEF, 0, 0, 0, 0, 6'b000010, 32'h100, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h200, 32'h11, 0, 0, 0, 0, 6'b000010, 32'h200, 0, 0));
        vecs.push_back(mk(1, 0, 1, 32'h204, 32'h22, 0, 0, 0, 0, 6'b000010, 32'h204, 0, 0));
        // Idle core, two DMA reads.
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h200, 0, 6'b000000, 32'h0, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h200, 0, 6'b101100, 32'h200, 0, 0));
        vecs.push_back(mk(1, 0, 0, 0, 0, 1, 0, 32'h204, 0, 6'b101101, 32'h204, 1, 32'h11));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b100001, 32'h0, 1, 32'h22));
        vecs.push_back(mk(1, 1, 0, 32'h100, 0, 0, 0, 0, 0, 6'b000100, 32'h100, 2, 32'hDEADBEEF));
        // Starvation bound: core busy, DMA waits 8 cycles, then 4 stalled beats.
        for (int k = 0; k < 8; k++)
            vecs.push_back(mk(1, 1, 0, 32'h100, 0, 1, 0, 32'h200, 0, 6'b000100, 32'h100, 2, 32'hDEADBEEF));
        for (int k = 0; k < 4; k++)
            vecs.push_back(mk(1, 1, 0, 32'h100, 0, 1, 0, 32'h200, 0,
                              (k == 0) ? 6'b111100 : 6'b111101, 32'h200,
                              (k == 0) ? 0 : 1, 32'h11));
        vecs.push_back(mk(1, 1, 0, 32'h100, 0, 1, 0, 32'h200, 0, 6'b000101, 32'h100, 2, 32'hDEADBEEF));
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 32'h0, 0, 0));

        // One unchecked reset cycle so registers hold known values.
        drive(0, 0, 1, 32'h100, 32'hDEADBEEF, 1, 0, MW, 32'h200, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst_n, vecs[i].crd, vecs[i].cwr, vecs[i].caddr, vecs[i].cwd,
                  vecs[i].dreq, vecs[i].dwe, MW, vecs[i].daddr, vecs[i].dwd);
            cyc($sformatf("vec%0d ctl", i), vecs[i].e_ctl);
            chk($sformatf("vec%0d mem_addr", i), mem_addr, vecs[i].e_maddr);
            if (vecs[i].dchk == 1)
                chk($sformatf("vec%0d dma_rdata", i), dma_rdata, vecs[i].e_data);
            else if (vecs[i].dchk == 2)
                chk($sformatf("vec%0d core_out", i), core_out, vecs[i].e_data);
        end

        // Burst preemption: 10-beat DMA write, core reads from beat 2.
        drive(1, 0, 0, 0, 0, 1, 1, MW, 32'h240, 32'hA0);
        cyc("pre t0", 6'b000000);
        for (int b = 0; b < 6; b++) begin
            drive(1, (b >= 2), 0, 32'h100, 0, 1, 1, MW, 32'h240 + 32'(4 * b), 32'hA0 + 32'(b));
            cyc($sformatf("pre beat%0d", b), (b >= 2) ? 6'b111010 : 6'b101010);
        end
        drive(1, 1, 0, 32'h100, 0, 1, 1, MW, 32'h258, 32'hA6);
        cyc("pre core served", 6'b000100);
        chk("pre core data", core_out, 32'hDEADBEEF);
        drive(1, 0, 0, 0, 0, 1, 1, MW, 32'h258, 32'hA6);
        cyc("pre regrant", 6'b000000);
        for (int b = 6; b < 10; b++) begin
            drive(1, 0, 0, 0, 0, 1, 1, MW, 32'h240 + 32'(4 * b), 32'hA0 + 32'(b));
            cyc($sformatf("pre beat%0d", b), 6'b101010);
        end
        drive(1, 0, 0, 0, 0, 0, 0, MW, 0, 0);
        cyc("pre drop", 6'b100000);
        drive(1, 0, 0, 0, 0, 0, 0, MW, 0, 0);
        cyc("pre back", 6'b000000);
        for (int i = 0; i < 10; i++)
            core_read_chk($sformatf("pre mem%0d", i), 32'h240 + 32'(4 * i), 32'hA0 + 32'(i));

        // Mid-burst reset: beat 3 must not be written.
        core_write(32'h28C, 32'h55555555);
        drive(1, 0, 0, 0, 0, 1, 1, MW, 32'h280, 32'hB0);
        cyc("rst t0", 6'b000000);
        for (int b = 0; b < 3; b++) begin
            drive(1, 0, 0, 0, 0, 1, 1, MW, 32'h280 + 32'(4 * b), 32'hB0 + 32'(b));
            cyc($sformatf("rst beat%0d", b), 6'b101010);
        end
        drive(0, 0, 0, 0, 0, 1, 1, MW, 32'h28C, 32'hB3);
        cyc("rst beat3 blocked", 6'b100000);
        drive(1, 0, 0, 0, 0, 0, 0, MW, 0, 0);
        cyc("rst after", 6'b000000);
        core_read_chk("rst beat3 unwritten", 32'h28C, 32'h55555555);
        core_read_chk("rst beat2 written", 32'h288, 32'hB2);

        // Mode passthrough: DMA byte store inside a core-written word.
        core_write(32'h300, 32'h44332211);
        drive(1, 0, 0, 0, 0, 1, 1, MB, 32'h301, 32'hAB);
        cyc("mode t0", 6'b000000);
        drive(1, 0, 0, 0, 0, 1, 1, MB, 32'h301, 32'hAB);
        cyc("mode beat", 6'b101010);
        chk("mode mem_mode", {29'd0, mem_mode}, {29'd0, MB});
        chk("mode mem_wd", mem_wd, 32'hAB);
        drive(1, 0, 0, 0, 0, 0, 0, MW, 0, 0);
        cyc("mode drop", 6'b100000);
        core_read_chk("mode word", 32'h300, 32'h4433AB11);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
